// File: rtl/hex_word_parser_pkg.sv
// Shared constants and FSM encoding for the ASCII hex word parser.
package hex_word_parser_pkg;

    localparam int unsigned CHAR_W = 8;
    localparam int unsigned NIB_W  = 4;

    localparam logic [CHAR_W-1:0] ASCII_CR = 8'h0D;
    localparam logic [CHAR_W-1:0] ASCII_LF = 8'h0A;
    localparam logic [CHAR_W-1:0] ASCII_SP = 8'h20;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCUM   = 2'd1,
        ST_DISCARD = 2'd2
    } parse_state_t;

endpackage

// File: rtl/ascii_to_nibble.sv
// Combinational ASCII character classifier: hex digit value, terminator flag.
module ascii_to_nibble
    import hex_word_parser_pkg::*;
(
    input  logic [CHAR_W-1:0] i_ascii,
    output logic [NIB_W-1:0]  o_nibble,
    output logic              o_is_digit,
    output logic              o_is_term
);

    // Decode digit ranges to their nibble value; everything else is non-digit.
    always_comb begin
        o_nibble   = '0;
        o_is_digit = 1'b0;
        o_is_term  = 1'b0;
        if (i_ascii >= 8'h30 && i_ascii <= 8'h39) begin
            o_nibble   = NIB_W'(i_ascii - 8'h30);
            o_is_digit = 1'b1;
        end else if (i_ascii >= 8'h41 && i_ascii <= 8'h46) begin
            o_nibble   = NIB_W'(i_ascii - 8'h37);
            o_is_digit = 1'b1;
        end else if (i_ascii >= 8'h61 && i_ascii <= 8'h66) begin
            o_nibble   = NIB_W'(i_ascii - 8'h57);
            o_is_digit = 1'b1;
        end else if (i_ascii == ASCII_CR || i_ascii == ASCII_LF || i_ascii == ASCII_SP) begin
            o_is_term  = 1'b1;
        end
    end

endmodule

// File: rtl/hex_word_parser.sv
// Parses whitespace/CR/LF-terminated ASCII hex tokens into a W-bit word.
module hex_word_parser
    import hex_word_parser_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [7:0]              i_data,
    input  logic                    i_valid,
    output logic [4*NUM_DIGITS-1:0] o_word,
    output logic                    o_word_valid,
    output logic                    o_error,
    output logic                    o_busy
);

    localparam int unsigned W  = 4 * NUM_DIGITS;
    localparam int unsigned CW = $clog2(NUM_DIGITS + 1);

    parse_state_t     state;
    logic [W-1:0]     acc;
    logic [CW-1:0]    count;
    logic [NIB_W-1:0] nibble;
    logic             is_digit;
    logic             is_term;

    ascii_to_nibble u_classify (
        .i_ascii    (i_data),
        .o_nibble   (nibble),
        .o_is_digit (is_digit),
        .o_is_term  (is_term)
    );

    // Token FSM with accumulator and registered result/pulse outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= ST_IDLE;
            acc          <= '0;
            count        <= '0;
            o_word       <= '0;
            o_word_valid <= 1'b0;
            o_error      <= 1'b0;
            o_busy       <= 1'b0;
        end else begin
            o_word_valid <= 1'b0;
            o_error      <= 1'b0;
            if (i_valid) begin
                case (state)
                    ST_IDLE: begin
                        if (is_digit) begin
                            acc    <= W'(nibble);
                            count  <= CW'(1);
                            state  <= ST_ACCUM;
                            o_busy <= 1'b1;
                        end else if (!is_term) begin
                            state  <= ST_DISCARD;
                            o_busy <= 1'b1;
                        end
                    end
                    ST_ACCUM: begin
                        if (is_digit) begin
                            if (count == CW'(NUM_DIGITS)) begin
                                state <= ST_DISCARD;
                            end else begin
                                acc   <= (acc << 4) | W'(nibble);
                                count <= count + CW'(1);
                            end
                        end else if (is_term) begin
                            o_word       <= acc;
                            o_word_valid <= 1'b1;
                            state        <= ST_IDLE;
                            o_busy       <= 1'b0;
                        end else begin
                            state <= ST_DISCARD;
                        end
                    end
                    ST_DISCARD: begin
                        if (is_term) begin
                            o_error <= 1'b1;
                            state   <= ST_IDLE;
                            o_busy  <= 1'b0;
                        end
                    end
                    default: begin
                        state  <= ST_IDLE;
                        o_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/hex_word_parser.md
HEX_WORD_PARSER -- requirements
Module: hex_word_parser

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, maximum hex digits per word; output width W = 4*NUM_DIGITS.
REQ-002 SHALL have port i_clk  input  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port i_data  input  8  ASCII character, typically from UART receiver.
REQ-005 SHALL have port i_valid  input  1  one-cycle strobe; i_data is sampled when high.
REQ-006 SHALL have port o_word  output  W  last successfully parsed value.
REQ-007 SHALL have port o_word_valid  output  1  one-cycle pulse when o_word is updated.
REQ-008 SHALL have port o_error  output  1  one-cycle pulse when a malformed token is terminated.
REQ-009 SHALL have port o_busy  output  1  high while a token is partially received (state ACCUM or DISCARD).

Function
REQ-010 SHALL classify each accepted character as: digit ('0'-'9', 'A'-'F', 'a'-'f', value 0-15), terminator (CR 0x0D, LF 0x0A, space 0x20), or invalid (all others).
REQ-011 SHALL implement FSM states IDLE, ACCUM, DISCARD; no backpressure, every i_valid strobe consumed.
REQ-012 IDLE: digit -> load accumulator with nibble, count=1, go ACCUM; terminator -> ignored, stay IDLE; invalid -> go DISCARD.
REQ-013 ACCUM: digit with count<NUM_DIGITS -> acc = {acc[W-5:0], nibble}, count+1; digit with count=NUM_DIGITS -> overflow, go DISCARD.
REQ-014 ACCUM: terminator -> o_word <= acc, o_word_valid pulses next cycle, go IDLE; invalid -> go DISCARD.
REQ-015 DISCARD: digits and invalid chars dropped; terminator -> o_error pulses next cycle, go IDLE.
REQ-016 Tokens shorter than NUM_DIGITS SHALL be right-justified, zero-extended ("1F" -> 0x001F with W=16).
REQ-017 Latency: o_word_valid/o_error SHALL assert exactly 1 cycle after the clock edge sampling the terminator, for exactly 1 cycle.
REQ-018 o_word SHALL hold its value between updates; unchanged on error.
REQ-019 o_word_valid and o_error SHALL never assert in the same cycle.
REQ-020 Consecutive terminators (CR LF, multiple spaces) SHALL produce at most one output pulse.
REQ-021 Back-to-back i_valid on every cycle SHALL be supported with no lost characters.
REQ-022 Accumulator and count SHALL not change on cycles with i_valid low.

Reset
REQ-023 While i_rst_n low: state=IDLE, accumulator=0, count=0, o_word=0, o_word_valid=0, o_error=0, o_busy=0.
REQ-024 Reset mid-token SHALL discard the partial token; no pulse after release.
REQ-025 First character after reset release SHALL be processed normally.

Structure
REQ-026 Shared package/include SHALL hold ASCII_CR, ASCII_LF, ASCII_SP constants and FSM state encodings.
REQ-027 Character classification SHALL be a combinational sub-module ascii_to_nibble (i_ascii[7:0] -> o_nibble[3:0], o_is_digit, o_is_term), the inverse of the existing nibble-to-ASCII converter.
REQ-028 Accumulator, count (clog2(NUM_DIGITS+1) bits) and FSM SHALL live in hex_word_parser.

Verification
REQ-029 Send "1A2b" CR -> one o_word_valid pulse, o_word=0x1A2B, o_error never high.
REQ-030 Send "7" CR LF -> o_word=0x0007, exactly one o_word_valid pulse; LF produces nothing.
REQ-031 Send "12345" CR -> o_error pulse one cycle after CR, o_word keeps prior value.
REQ-032 Send "1G" space then "FF" LF -> o_error after space, then o_word=0x00FF valid after LF.
REQ-033 Send "AB", assert i_rst_n low for 2 cycles, release, send CR then "C" CR -> no pulse after first CR; o_word=0x000C.
REQ-034 Stream "FFFF CR 0000 CR" with i_valid high every cycle -> o_word 0xFFFF then 0x0000, two pulses, no lost characters.
